// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: clocked EX-stage ALU with iterative multiply/divide into HI/LO.
// Single-cycle ops register their result on the accept edge. MULT/DIV run
// WIDTH shift-add / restoring-divide iterations on operand magnitudes,
// followed by one sign-fix edge.
// Optional build macro: MULDIV_FASTZERO_EN. When defined, MULT with a zero
// operand and DIV by zero finish on the accept edge.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [4:0]       ALUCtl,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b10000;
    localparam logic [4:0] OP_SRL  = 5'b11000;
    localparam logic [4:0] OP_SRA  = 5'b11001;
    localparam logic [4:0] OP_MULT = 5'b11100;
    localparam logic [4:0] OP_DIV  = 5'b11101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0]   shr_q, shr_d;     // multiplier->product low half / dividend->quotient
    logic [WIDTH-1:0]   opb_q, opb_d;     // |multiplicand| or |divisor|
    logic               neg_q, neg_d;     // negate product / quotient at fix-up
    logic               rneg_q, rneg_d;   // negate remainder (dividend was negative)
    logic               div_q, div_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               vld_q, vld_d;
    logic               ready_q, ready_d;

    logic               a_neg, b_neg, fast;
    logic [WIDTH:0]     sum_w, rem_sh, diff_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH-1:0]   q_res, r_res;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] alu_single(input logic [4:0] ctl, input logic sgn,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [SH_W-1:0]         sh;
        logic [WIDTH-1:0]        r;
        a_s = a;
        b_s = b;
        sh  = a[SH_W-1:0];
        case (ctl)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sgn ? (a_s < b_s) : (a < b))};
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = b << sh;
            OP_SRL:  r = b >> sh;
            OP_SRA:  r = b_s >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Next-state, datapath iteration and result selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shr_d   = shr_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        out_d   = out_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        vld_d   = 1'b0;

        a_neg = Sign & in1[WIDTH-1];
        b_neg = Sign & in2[WIDTH-1];
`ifdef MULDIV_FASTZERO_EN
        fast = (ALUCtl == OP_DIV) ? (in2 == '0) : ((in1 == '0) || (in2 == '0));
`else
        fast = 1'b0;
`endif

        sum_w  = {1'b0, acc_q} + {1'b0, (shr_q[0] ? opb_q : '0)};
        rem_sh = {acc_q, shr_q[WIDTH-1]};
        diff_w = rem_sh - {1'b0, opb_q};
        prod_w = {acc_q, shr_q};
        if (neg_q) prod_w = -prod_w;
        q_res = neg_if(shr_q, neg_q);
        r_res = neg_if(acc_q, rneg_q);

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (ALUCtl == OP_MULT || ALUCtl == OP_DIV) begin
                        if (fast) begin
                            hi_d   = (ALUCtl == OP_DIV) ? in1 : '0;
                            lo_d   = (ALUCtl == OP_DIV) ? '1  : '0;
                            out_d  = lo_d;
                            zero_d = (lo_d == '0);
                            vld_d  = 1'b1;
                        end else begin
                            acc_d   = '0;
                            shr_d   = neg_if(in1, a_neg);
                            opb_d   = neg_if(in2, b_neg);
                            neg_d   = (a_neg ^ b_neg) & (in2 != '0);
                            rneg_d  = a_neg;
                            div_d   = (ALUCtl == OP_DIV);
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = (ALUCtl == OP_DIV) ? S_DIV : S_MUL;
                        end
                    end else begin
                        out_d  = alu_single(ALUCtl, Sign, in1, in2);
                        zero_d = (out_d == '0);
                        vld_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = sum_w[WIDTH:1];
                shr_d = {sum_w[0], shr_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (!diff_w[WIDTH]) begin
                    acc_d = diff_w[WIDTH-1:0];
                    shr_d = {shr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    shr_d = {shr_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    lo_d = q_res;
                    hi_d = r_res;
                end else begin
                    {hi_d, lo_d} = prod_w;
                end
                out_d   = lo_d;
                zero_d  = (lo_d == '0);
                vld_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and result registers; async reset aborts any op in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            shr_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
            vld_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shr_q   <= shr_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            vld_q   <= vld_d;
            ready_q <= ready_d;
        end
    end

    assign ready_out = ready_q;
    assign out_valid = vld_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: behavioural model + scoreboard queue, with a
// WIDTH=32 instance for the main run and a WIDTH=8 instance for a short run.
module tb_alu_muldiv_seq;

    localparam int W = 32;
    localparam bit [4:0] OP_ADD  = 5'b00010;
    localparam bit [4:0] OP_SUB  = 5'b00110;
    localparam bit [4:0] OP_SLT  = 5'b00111;
    localparam bit [4:0] OP_SRA  = 5'b11001;
    localparam bit [4:0] OP_MULT = 5'b11100;
    localparam bit [4:0] OP_DIV  = 5'b11101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [4:0]  ALUCtl = '0;
    logic        Sign = 1'b0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        out_valid;
    logic [31:0] out, hi, lo;
    logic        zero;

    logic        valid8 = 1'b0, sign8 = 1'b0;
    logic [4:0]  ctl8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        rdy8, ov8, zero8;
    logic [7:0]  out8, hi8, lo8;

    alu_muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .ALUCtl(ALUCtl), .Sign(Sign), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out(out), .zero(zero), .hi(hi), .lo(lo)
    );

    alu_muldiv_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .valid_in(valid8), .ready_out(rdy8),
        .ALUCtl(ctl8), .Sign(sign8), .in1(a8), .in2(b8),
        .out_valid(ov8), .out(out8), .zero(zero8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int        due;
        bit [31:0] out;
        bit        zero;
        bit [31:0] hi;
        bit [31:0] lo;
    } exp_t;

    exp_t      exp_q[$];
    exp_t      cmp_x;
    bit [31:0] m_hi = '0, m_lo = '0;
    int        free_edge = 0;

    bit [4:0] ops [14] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111,
                          5'b01100, 5'b01101, 5'b10000, 5'b11000, 5'b11001,
                          5'b11100, 5'b11101, 5'b00011, 5'b11111};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic longint sx(input longint unsigned v, input int w);
        if (v[w-1]) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    // Reference MULT/DIV from plain integer arithmetic
    function automatic void model_md(input int w, input bit is_div, input bit sg,
                                     input longint unsigned a, input longint unsigned b,
                                     output longint unsigned mh, output longint unsigned ml);
        longint unsigned mask, p;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = sg ? sx(a, w) : longint'(a);
        sb = sg ? sx(b, w) : longint'(b);
        if (!is_div) begin
            p  = sg ? longint'(sa * sb) : a * b;
            mh = (p >> w) & mask;
            ml = p & mask;
        end else if (b == 0) begin
            ml = mask;
            mh = a & mask;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            ml = longint'(q) & mask;
            mh = longint'(r) & mask;
        end
    endfunction

    function automatic bit [31:0] model_alu(input bit [4:0] op, input bit sg,
                                            input bit [31:0] a, input bit [31:0] b);
        bit signed [31:0] bs;
        int sh;
        bs = b;
        sh = int'(a[4:0]);
        case (op)
            5'b00000: return a & b;
            5'b00001: return a | b;
            5'b00010: return a + b;
            5'b00110: return a - b;
            5'b00111: return sg ? 32'($signed(a) < $signed(b)) : 32'(a < b);
            5'b01100: return ~(a | b);
            5'b01101: return a ^ b;
            5'b10000: return b << sh;
            5'b11000: return b >> sh;
            5'b11001: return bs >>> sh;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic bit [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Compare process: every completion must match the next scoreboard entry
    always @(negedge clk) begin
        if (reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                cmp_x = exp_q.pop_front();
                chk("out_valid", out_valid, 1);
                chk("out", out, cmp_x.out);
                chk("zero", zero, cmp_x.zero);
                chk("hi", hi, cmp_x.hi);
                chk("lo", lo, cmp_x.lo);
            end else if (out_valid) begin
                chk("out_valid_spurious", out_valid, 0);
            end
        end
    end

    task automatic issue(input bit [4:0] op, input bit sg, input bit [31:0] a, input bit [31:0] b);
        int e, lat;
        bit rdy, fast;
        exp_t x;
        longint unsigned h, l;
        @(negedge clk);
        e   = cyc + 1;
        rdy = (e >= free_edge);
        chk("ready_out", ready_out, rdy);
        valid_in = 1'b1; ALUCtl = op; Sign = sg; in1 = a; in2 = b;
        if (rdy) begin
            fast = 1'b0;
            if (op == OP_MULT || op == OP_DIV) begin
`ifdef MULDIV_FASTZERO_EN
                fast = (op == OP_DIV) ? (b == 0) : (a == 0 || b == 0);
`endif
                model_md(32, op == OP_DIV, sg, a, b, h, l);
                m_hi  = h[31:0];
                m_lo  = l[31:0];
                x.out = m_lo;
                lat   = fast ? 1 : W + 2;
            end else begin
                x.out = model_alu(op, sg, a, b);
                lat   = 1;
            end
            x.zero = (x.out == 0);
            x.hi   = m_hi;
            x.lo   = m_lo;
            x.due  = e + lat - 1;
            exp_q.push_back(x);
            free_edge = e + lat;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        ALUCtl = 5'($urandom);
        in1 = $urandom;
        in2 = $urandom;
    endtask

    task automatic wait_free();
        while (cyc + 1 < free_edge) idle();
    endtask

    task automatic run8(input bit [4:0] op, input bit sg, input bit [7:0] a, input bit [7:0] b);
        longint unsigned h, l;
        int lat;
        @(negedge clk);
        chk("ready8", rdy8, 1);
        valid8 = 1'b1; ctl8 = op; sign8 = sg; a8 = a; b8 = b;
        @(negedge clk);
        valid8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        model_md(8, op == OP_DIV, sg, a, b, h, l);
        chk("lat8", lat, 10);
        chk("hi8", hi8, h);
        chk("lo8", lo8, l);
        chk("out8", out8, l);
        chk("zero8", zero8, l == 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned h, l;

        // Model pins against hand-computed values
        model_md(32, 0, 1, 32'hFFFF_FFFF, 32'h2, h, l);
        chk("pin_smult_hi", h, 64'hFFFF_FFFF); chk("pin_smult_lo", l, 64'hFFFF_FFFE);
        model_md(32, 0, 0, 32'hFFFF_FFFF, 32'h2, h, l);
        chk("pin_umult_hi", h, 64'h1); chk("pin_umult_lo", l, 64'hFFFF_FFFE);
        model_md(32, 1, 1, 32'hFFFF_FFF9, 32'h2, h, l);
        chk("pin_sdiv_hi", h, 64'hFFFF_FFFF); chk("pin_sdiv_lo", l, 64'hFFFF_FFFD);
        model_md(32, 1, 0, 100, 7, h, l);
        chk("pin_udiv_hi", h, 2); chk("pin_udiv_lo", l, 14);
        model_md(32, 1, 1, 32'h1234_5678, 0, h, l);
        chk("pin_div0_hi", h, 64'h1234_5678); chk("pin_div0_lo", l, 64'hFFFF_FFFF);
        model_md(32, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
        chk("pin_minm1_hi", h, 0); chk("pin_minm1_lo", l, 64'h8000_0000);
        model_md(8, 0, 1, 8'h80, 8'h80, h, l);
        chk("pin_mult8_hi", h, 64'h40); chk("pin_mult8_lo", l, 0);
        chk("pin_sra", model_alu(OP_SRA, 0, 4, 32'h8000_0000), 64'hF800_0000);
        chk("pin_slt", model_alu(OP_SLT, 1, 32'hFFFF_FFFF, 1), 1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", ready_out, 1); chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0); chk("rst_zero", zero, 1);
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
        reset = 1'b1;

        // Back-to-back single-cycle ops
        issue(OP_SUB, 0, 5, 5);
        issue(OP_SLT, 1, 32'hFFFF_FFFF, 1);
        issue(OP_SRA, 0, 4, 32'h8000_0000);
        idle();

        // Directed MULT/DIV
        issue(OP_MULT, 1, 32'hFFFF_FFFF, 2); wait_free();
        issue(OP_MULT, 0, 32'hFFFF_FFFF, 2); wait_free();
        issue(OP_DIV, 1, 32'hFFFF_FFF9, 2);
        issue(OP_ADD, 0, 1, 1);
        issue(OP_ADD, 0, 2, 2);
        idle();
        issue(OP_SUB, 0, 9, 1);
        wait_free();
        issue(OP_DIV, 0, 100, 7); wait_free();
        issue(OP_DIV, 1, 32'h1234_5678, 0); wait_free();
        issue(OP_DIV, 0, 32'h1234_5678, 0); wait_free();
        issue(OP_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_free();
        issue(OP_MULT, 1, 0, 32'h1234); wait_free();

        // Reset mid-MULT after edge 10 of 34
        issue(OP_MULT, 1, 32'hFFFF_FFFF, 2);
        repeat (10) idle();
        reset = 1'b0;
        #1;
        chk("abort_ready", ready_out, 1); chk("abort_valid", out_valid, 0);
        chk("abort_out", out, 0); chk("abort_hi", hi, 0); chk("abort_lo", lo, 0);
        exp_q.delete();
        m_hi = '0; m_lo = '0; free_edge = 0;
        @(negedge clk);
        reset = 1'b1;
        issue(OP_ADD, 0, 3, 4);
        idle();

        // Randomized traffic, including requests while busy
        for (int i = 0; i < 160; i++) begin
            issue(ops[$urandom_range(0, 13)], 1'($urandom_range(0, 1)), pick(), pick());
            repeat ($urandom_range(0, 2)) idle();
        end

        begin
            int n = 0;
            while (exp_q.size() > 0 && n < 200) begin
                idle();
                n++;
            end
            chk("drain", exp_q.size(), 0);
        end

        // WIDTH=8 instance
        run8(OP_MULT, 1, 8'h80, 8'h80);
        for (int i = 0; i < 6; i++)
            run8((i % 2) ? OP_DIV : OP_MULT, 1'($urandom_range(0, 1)),
                 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, clocked successor to the single-cycle ALU in the pipeline CPU's EX stage.
- Keeps the existing 5-bit ALUCtl encodings and the Sign convention for all single-cycle ops, widened to WIDTH bits.
- Adds iterative multiply and divide units that write HI/LO registers.
- Uses a valid/ready handshake so the hazard unit can stall EX while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, datapath width. Power of two, >= 8. Shift amount is in1[$clog2(WIDTH)-1:0].

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- valid_in  in  1  operation request
- ready_out  out  1  block can accept a request; high only in IDLE
- ALUCtl  in  5  opcode
- Sign  in  1  1 = signed compare/mul/div
- in1  in  WIDTH  operand A (shift amount for shift ops)
- in2  in  WIDTH  operand B (shifted value for shift ops)
- out_valid  out  1  one-cycle pulse: out/zero are new
- out  out  WIDTH  result
- zero  out  1  (out == 0), registered alongside out
- hi  out  WIDTH  HI register (mul upper half / div remainder)
- lo  out  WIDTH  LO register (mul lower half / div quotient)

Behaviour:
- Reset (async, reset==0): state=IDLE; out, hi, lo, out_valid, counter and internal regs = 0; zero=1; ready_out=1. Reset mid-operation aborts the op with no HI/LO update.
- Accept: a request is taken on a rising edge with valid_in && ready_out. valid_in while busy is ignored; it is neither queued nor flagged.
- Single-cycle ops, registered, 1-edge latency (out_valid high in the cycle after the accept edge):
  - 00000 AND, 00001 OR, 00010 ADD (wraps mod 2^WIDTH), 00110 SUB
  - 00111 SLT: Sign ? signed : unsigned; result zero-extended
  - 01100 NOR, 01101 XOR
  - 10000 SLL in2<<sh, 11000 SRL in2>>sh, 11001 SRA arithmetic shift of in2
  - Any other opcode: out=0, zero=1, out_valid pulses.
- Multi-cycle ops: 11100 MULT and 11101 DIV; Sign selects signed/unsigned.
  - Accept edge: latch |in1|, |in2| (unsigned if Sign=0) and result-sign flags; counter=WIDTH; state=MUL or DIV.
  - Each following edge performs one iteration (shift-add multiply, restoring divide); counter decrements.
  - Iteration that brings counter to 0: state=FIX. The FIX edge applies sign correction, writes hi/lo, sets out=lo, state=IDLE, out_valid=1.
  - Latency: out_valid high WIDTH+2 edges after the accept edge (34 for WIDTH=32). ready_out returns high with out_valid.
- MULT: {hi,lo} = full 2*WIDTH-bit product; two's-complement when signed.
- DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - Divide by zero: lo = all ones, hi = in1 (signed and unsigned).
  - Signed MIN / -1: lo = MIN, hi = 0.
- hi/lo change only at completion of MULT/DIV. out holds its value until the next completion. out_valid is a one-cycle pulse.
- FSM: IDLE -> (MULT/DIV accepted) MUL|DIV -> FIX -> IDLE. Single-cycle ops stay in IDLE, so back-to-back accepts are allowed every cycle.

Optional Feature:
- MULDIV_FASTZERO_EN defined: MULT with in1==0 or in2==0, and DIV with in2==0, complete like single-cycle ops (1-edge latency), with the same hi/lo/out values as the full path.
- Undefined: these cases take the full WIDTH+2 latency.

Test Plan:
- Reset asserted mid-MULT (edge 10 of 34) -> immediately ready_out=1, out_valid=0, hi=lo=out=0; after release, a new ADD 3+4 gives out=7, zero=0.
- Back-to-back single-cycle ops: SUB 5-5, SLT Sign=1 0xFFFFFFFF vs 1, SRA in1=4 in2=0x80000000 on consecutive cycles -> out = 0 (zero=1), 1, 0xF8000000 on consecutive cycles, ready_out always 1.
- Signed MULT 0xFFFFFFFF * 0x00000002 -> exactly 34 edges later out_valid=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE, out=lo; unsigned same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned DIV 100/7 -> lo=14, hi=2; valid_in pulsed while busy -> no effect.
- DIV 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678. With MULDIV_FASTZERO_EN latency is 1 edge; without it, 34 edges.
- Signed DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Repeat with WIDTH=8: MULT 0x80*0x80 signed -> hi=0x40, lo=0x00, latency 10 edges.
